// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit CPU; drives imem, register-file and ALU controls.
// Optional ILLEGAL_TRAP_EN: opcodes B-E halt the core with the illegal flag set instead of NOP.
module cpu_control_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     DATA_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] alu_result,
    output logic [3:0]        alu_sel,
    output logic [1:0]        rf_ra,
    output logic [1:0]        rf_rb,
    output logic              rf_we,
    output logic [1:0]        rf_wa,
    output logic              rf_wsel,
    output logic [DATA_W-1:0] imm,
    output logic              zero_flag,
    output logic              halted,
    output logic              illegal
);

    localparam logic [2:0] StBoot   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StImm    = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              z_q, z_d;
    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [PC_W-1:0]   pc_inc;

    assign op        = ir_q[7:4];
    assign rd        = ir_q[3:2];
    assign rs        = ir_q[1:0];
    assign pc_inc    = pc_q + PC_W'(1);
    assign zero_flag = z_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        z_d       = z_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        imem_req  = 1'b0;
        imem_addr = '0;
        alu_sel   = 4'h0;
        rf_ra     = 2'd0;
        rf_rb     = 2'd0;
        rf_we     = 1'b0;
        rf_wa     = 2'd0;
        rf_wsel   = 1'b0;
        imm       = '0;
        halted    = 1'b0;

        case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_inc;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                rf_ra = rd;
                rf_rb = rs;
                if (!op[3]) begin
                    state_d = StExec;
                end else if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
                    state_d = StImm;
                end else if (op == 4'hF) begin
                    state_d = StHalt;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = StHalt;
`else
                    state_d   = StFetch;
`endif
                end
            end
            StExec: begin
                alu_sel = op;
                rf_ra   = rd;
                rf_rb   = rs;
                rf_we   = 1'b1;
                rf_wa   = rd;
                z_d     = (alu_result == '0);
                state_d = StFetch;
            end
            StImm: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_valid) begin
                    state_d = StFetch;
                    case (op)
                        4'h8: begin
                            rf_we   = 1'b1;
                            rf_wa   = rd;
                            rf_wsel = 1'b1;
                            imm     = imem_rdata;
                            z_d     = (imem_rdata == '0);
                            pc_d    = pc_inc;
                        end
                        4'h9:    pc_d = PC_W'(imem_rdata);
                        4'hA:    pc_d = z_q ? PC_W'(imem_rdata) : pc_inc;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            StHalt:  halted = 1'b1;
            default: state_d = StBoot;
        endcase
    end

endmodule
